// File: rtl/radix_8_ntt_scheduler_if.sv
// Issue/write-back bus between the NTT scheduler, its controller and the RAM/butterfly side.
// The scheduler uses the slave modport; the controller or bench uses master.
interface radix_8_ntt_scheduler_if #(
   parameter int unsigned LOG_NPT = 6
);
   logic                   start;
   logic                   issue_rdy;
   logic                   busy;
   logic                   done;
   logic                   rd_valid;
   logic [8*LOG_NPT-1:0]   rd_addr;
   logic [7*LOG_NPT-1:0]   tf_exp;
   logic                   wr_en;
   logic [8*LOG_NPT-1:0]   wr_addr;

   modport master (
      output start, issue_rdy,
      input  busy, done, rd_valid, rd_addr, tf_exp, wr_en, wr_addr
   );

   modport slave (
      input  start, issue_rdy,
      output busy, done, rd_valid, rd_addr, tf_exp, wr_en, wr_addr
   );
endinterface

// File: rtl/radix_8_ntt_scheduler.sv
// Sequences an NPT-point radix-8 DIT NTT: one butterfly group issued per granted cycle,
// write-back addresses replayed BF_LAT cycles later through a fixed shift register.
module radix_8_ntt_scheduler #(
   parameter int unsigned LOG_NPT = 6,
   parameter int unsigned BF_LAT  = 3
) (
   input logic                    clk,
   input logic                    rst,
   radix_8_ntt_scheduler_if.slave bus
);
   localparam int unsigned NPT = 1 << LOG_NPT;
   localparam int unsigned S   = LOG_NPT / 3;
   localparam int unsigned SHW = $clog2(LOG_NPT + 1);
   localparam int unsigned CW  = (BF_LAT > 1) ? $clog2(BF_LAT) : 1;
   localparam int unsigned AW  = 8 * LOG_NPT;
   localparam int unsigned TW  = 7 * LOG_NPT;

   localparam logic [LOG_NPT-1:0] LAST_G     = LOG_NPT'(NPT / 8 - 1);
   localparam logic [SHW-1:0]     LAST_STAGE = SHW'(S - 1);
   localparam logic [CW-1:0]      LAST_CNT   = CW'(BF_LAT - 1);

   typedef enum logic [1:0] {StIdle, StIssue, StDrain, StDone} state_t;

   state_t             state_q;
   logic [SHW-1:0]     stage_q;
   logic [LOG_NPT-1:0] g_q;
   logic [CW-1:0]      cnt_q;
   logic [AW-1:0]      rd_addr_q;
   logic [TW-1:0]      tf_exp_q;
   logic               pipe_v_q [BF_LAT];
   logic [AW-1:0]      pipe_a_q [BF_LAT];

   logic               issue;
   logic [SHW-1:0]     shift;
   logic [SHW-1:0]     tf_shift;
   logic [LOG_NPT-1:0] j;
   logic [LOG_NPT-1:0] base;
   logic [LOG_NPT-1:0] prod;
   logic [AW-1:0]      addr_c;
   logic [TW-1:0]      tf_c;

   assign issue = (state_q == StIssue) && bus.issue_rdy;

   // span = 8^stage = 1 << shift; j = g mod span, blk = g / span via mask and shift
   always_comb begin
      shift    = stage_q * SHW'(3);
      tf_shift = SHW'(LOG_NPT - 3) - shift;
      j        = g_q & ~({LOG_NPT{1'b1}} << shift);
      base     = ((g_q >> shift) << (shift + SHW'(3))) | j;
      addr_c   = '0;
      tf_c     = '0;
      prod     = '0;
      for (int k = 0; k < 8; k++) begin
         addr_c[k*LOG_NPT +: LOG_NPT] = base + (LOG_NPT'(k) << shift);
      end
      for (int k = 1; k < 8; k++) begin
         prod                             = LOG_NPT'(k) * j;
         tf_c[(k-1)*LOG_NPT +: LOG_NPT]   = prod << tf_shift;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= StIdle;
         stage_q   <= '0;
         g_q       <= '0;
         cnt_q     <= '0;
         rd_addr_q <= '0;
         tf_exp_q  <= '0;
         for (int i = 0; i < BF_LAT; i++) begin
            pipe_v_q[i] <= 1'b0;
            pipe_a_q[i] <= '0;
         end
      end else begin
         // The latency pipe free-runs; a stall only inserts bubbles.
         pipe_v_q[0] <= issue;
         pipe_a_q[0] <= issue ? addr_c : '0;
         for (int i = 1; i < BF_LAT; i++) begin
            pipe_v_q[i] <= pipe_v_q[i-1];
            pipe_a_q[i] <= pipe_a_q[i-1];
         end

         if (issue) begin
            rd_addr_q <= addr_c;
            tf_exp_q  <= tf_c;
         end

         unique case (state_q)
            StIdle: begin
               if (bus.start) begin
                  state_q <= StIssue;
                  stage_q <= '0;
                  g_q     <= '0;
               end
            end
            StIssue: begin
               if (bus.issue_rdy) begin
                  if (g_q == LAST_G) begin
                     state_q <= StDrain;
                     cnt_q   <= '0;
                  end else begin
                     g_q <= g_q + 1'b1;
                  end
               end
            end
            StDrain: begin
               if (cnt_q == LAST_CNT) begin
                  if (stage_q == LAST_STAGE) begin
                     state_q <= StDone;
                  end else begin
                     stage_q <= stage_q + 1'b1;
                     g_q     <= '0;
                     state_q <= StIssue;
                  end
               end else begin
                  cnt_q <= cnt_q + 1'b1;
               end
            end
            StDone: begin
               state_q <= StIdle;
            end
            default: begin
               state_q <= StIdle;
            end
         endcase
      end
   end

   assign bus.busy     = (state_q != StIdle);
   assign bus.done     = (state_q == StDone);
   assign bus.rd_valid = issue;
   assign bus.rd_addr  = issue ? addr_c : rd_addr_q;
   assign bus.tf_exp   = issue ? tf_c : tf_exp_q;
   assign bus.wr_en    = pipe_v_q[BF_LAT-1];
   assign bus.wr_addr  = pipe_a_q[BF_LAT-1];
endmodule

// File: tb/tb_radix_8_ntt_scheduler.sv
// Scoreboard bench for radix_8_ntt_scheduler: expected groups queued at start, popped on
// rd_valid, replayed as expected write-backs and checked on wr_en.
module tb_radix_8_ntt_scheduler;
   localparam int unsigned L   = 6;
   localparam int unsigned LAT = 3;
   localparam int unsigned NPT = 1 << L;
   localparam int unsigned S   = L / 3;
   localparam int unsigned NG  = NPT / 8;

   typedef struct {
      logic [8*L-1:0] a;
      logic [7*L-1:0] t;
   } grp_t;

   logic clk;
   logic rst;
   int   cyc;
   int   t0;
   int   n_checks;
   int   n_errors;

   grp_t           exp_rd[$];
   logic [8*L-1:0] exp_wr[$];
   int             exp_wr_cyc[$];
   int             rd_cyc[$];
   int             done_cyc[$];
   int             busy_fall[$];
   grp_t           mon_g;
   logic [8*L-1:0] mon_wa;
   int             mon_wc;
   logic [8*L-1:0] last_a;
   logic [7*L-1:0] last_t;
   logic           prev_busy;

   radix_8_ntt_scheduler_if #(.LOG_NPT(L)) bus ();

   radix_8_ntt_scheduler #(
      .LOG_NPT (L),
      .BF_LAT  (LAT)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
      end
   endtask

   function automatic int q_rel(input int q[$], input int i);
      if (i < q.size()) return q[i] - t0;
      return -1;
   endfunction

   // Expected groups straight from the addressing formulas (div/mod form).
   task automatic push_groups();
      grp_t e;
      int   span, j, blk, base;
      for (int s = 0; s < S; s++) begin
         span = 8 ** s;
         for (int g = 0; g < NG; g++) begin
            j    = g % span;
            blk  = g / span;
            base = blk * 8 * span + j;
            e.a  = '0;
            e.t  = '0;
            for (int k = 0; k < 8; k++) e.a[k*L +: L] = L'(base + k * span);
            for (int k = 1; k < 8; k++) e.t[(k-1)*L +: L] = L'((k * j * (NPT / (8 * span))) % NPT);
            exp_rd.push_back(e);
         end
      end
   endtask

   always @(posedge clk) begin
      cyc++;
      if (rst) begin
         exp_rd.delete();
         exp_wr.delete();
         exp_wr_cyc.delete();
         last_a = '0;
         last_t = '0;
      end
   end

   always @(negedge clk) begin
      if (!rst) begin
         if (bus.rd_valid) begin
            check_eq("rd_expected", 128'(exp_rd.size() != 0), 128'(1));
            if (exp_rd.size() != 0) begin
               mon_g = exp_rd.pop_front();
               check_eq("rd_addr", 128'(bus.rd_addr), 128'(mon_g.a));
               check_eq("tf_exp", 128'(bus.tf_exp), 128'(mon_g.t));
               exp_wr.push_back(mon_g.a);
               exp_wr_cyc.push_back(cyc + LAT);
               last_a = mon_g.a;
               last_t = mon_g.t;
            end
            rd_cyc.push_back(cyc);
         end else begin
            check_eq("rd_hold", 128'({bus.rd_addr, bus.tf_exp}), 128'({last_a, last_t}));
         end
         if (bus.wr_en) begin
            check_eq("wr_expected", 128'(exp_wr.size() != 0), 128'(1));
            if (exp_wr.size() != 0) begin
               mon_wa = exp_wr.pop_front();
               mon_wc = exp_wr_cyc.pop_front();
               check_eq("wr_addr", 128'(bus.wr_addr), 128'(mon_wa));
               check_eq("wr_cycle", 128'(cyc), 128'(mon_wc));
            end
         end
         if (bus.done) begin
            check_eq("done_pipe_empty", 128'(exp_wr.size() + exp_rd.size()), 128'(0));
            check_eq("done_wr_idle", 128'(bus.wr_en), 128'(0));
            done_cyc.push_back(cyc);
         end
         if (prev_busy && !bus.busy) busy_fall.push_back(cyc);
      end
      prev_busy = bus.busy;
   end

   task automatic step(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   // Drives one scenario cycle by cycle; rel 0 is the cycle the first start is presented.
   task automatic run(input int stall_lo, input int stall_hi, input int ign0, input int ign1,
                      input int restart, input int abort_at, input int n_cyc);
      t0 = cyc;
      rd_cyc.delete();
      done_cyc.delete();
      busy_fall.delete();
      for (int rel = 0; rel < n_cyc; rel++) begin
         if (rel == 0 || rel == restart) push_groups();
         bus.start     = (rel == 0) || (rel == ign0) || (rel == ign1) || (rel == restart);
         bus.issue_rdy = !(rel >= stall_lo && rel <= stall_hi);
         rst           = (rel == abort_at);
         step(1);
      end
      bus.start     = 1'b0;
      bus.issue_rdy = 1'b1;
      rst           = 1'b0;
   endtask

   task automatic check_nominal();
      check_eq("nom_rd_count", 128'(rd_cyc.size()), 128'(16));
      check_eq("nom_first_rd", 128'(q_rel(rd_cyc, 0)), 128'(1));
      check_eq("nom_s0_last_rd", 128'(q_rel(rd_cyc, 7)), 128'(8));
      check_eq("nom_s1_first_rd", 128'(q_rel(rd_cyc, 8)), 128'(12));
      check_eq("nom_s1_last_rd", 128'(q_rel(rd_cyc, 15)), 128'(19));
      check_eq("nom_done_count", 128'(done_cyc.size()), 128'(1));
      check_eq("nom_done_cycle", 128'(q_rel(done_cyc, 0)), 128'(23));
      check_eq("nom_busy_fall", 128'(q_rel(busy_fall, 0)), 128'(24));
      check_eq("nom_wr_drained", 128'(exp_wr.size() + exp_rd.size()), 128'(0));
   endtask

   initial begin
      n_checks      = 0;
      n_errors      = 0;
      cyc           = 0;
      t0            = 0;
      last_a        = '0;
      last_t        = '0;
      prev_busy     = 1'b0;
      rst           = 1'b1;
      bus.start     = 1'b1;
      bus.issue_rdy = 1'b1;

      repeat (2) @(posedge clk);
      @(negedge clk);
      check_eq("rst_busy", 128'(bus.busy), 128'(0));
      check_eq("rst_done", 128'(bus.done), 128'(0));
      check_eq("rst_rd_valid", 128'(bus.rd_valid), 128'(0));
      check_eq("rst_wr_en", 128'(bus.wr_en), 128'(0));
      check_eq("rst_rd_addr", 128'(bus.rd_addr), 128'(0));
      check_eq("rst_tf_exp", 128'(bus.tf_exp), 128'(0));
      check_eq("rst_wr_addr", 128'(bus.wr_addr), 128'(0));
      @(posedge clk);
      #1;
      rst       = 1'b0;
      bus.start = 1'b0;
      step(3);

      run(-1, -1, -1, -1, -1, -1, 30);
      check_nominal();
      step(2);

      run(3, 5, -1, -1, -1, -1, 32);
      check_eq("stall_rd_count", 128'(rd_cyc.size()), 128'(16));
      check_eq("stall_g1_rd", 128'(q_rel(rd_cyc, 1)), 128'(2));
      check_eq("stall_g2_rd", 128'(q_rel(rd_cyc, 2)), 128'(6));
      check_eq("stall_s0_last_rd", 128'(q_rel(rd_cyc, 7)), 128'(11));
      check_eq("stall_s1_first_rd", 128'(q_rel(rd_cyc, 8)), 128'(15));
      check_eq("stall_s1_last_rd", 128'(q_rel(rd_cyc, 15)), 128'(22));
      check_eq("stall_done_cycle", 128'(q_rel(done_cyc, 0)), 128'(26));
      check_eq("stall_busy_fall", 128'(q_rel(busy_fall, 0)), 128'(27));
      step(2);

      run(-1, -1, 5, 23, 25, -1, 60);
      check_eq("restart_rd_count", 128'(rd_cyc.size()), 128'(32));
      check_eq("restart_first_rd", 128'(q_rel(rd_cyc, 16)), 128'(26));
      check_eq("restart_done_count", 128'(done_cyc.size()), 128'(2));
      check_eq("restart_done0", 128'(q_rel(done_cyc, 0)), 128'(23));
      check_eq("restart_done1", 128'(q_rel(done_cyc, 1)), 128'(48));
      check_eq("restart_busy_fall", 128'(q_rel(busy_fall, 0)), 128'(24));
      step(2);

      run(-1, -1, -1, -1, -1, 10, 35);
      check_eq("abort_rd_count", 128'(rd_cyc.size()), 128'(8));
      check_eq("abort_done_count", 128'(done_cyc.size()), 128'(0));
      check_eq("abort_busy_fall", 128'(q_rel(busy_fall, 0)), 128'(11));
      check_eq("abort_idle_busy", 128'(bus.busy), 128'(0));
      step(2);

      run(-1, -1, -1, -1, -1, -1, 30);
      check_nominal();

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end
endmodule
